// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU control bits,
// operation encodings and FSM state encoding.
package alu_op_sequencer_pkg;

  localparam logic [5:0] ZX = 6'd32;
  localparam logic [5:0] NX = 6'd16;
  localparam logic [5:0] ZY = 6'd8;
  localparam logic [5:0] NY = 6'd4;
  localparam logic [5:0] F  = 6'd2;
  localparam logic [5:0] NO = 6'd1;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_ADD,
    S_MUL_DBL,
    S_SHL,
    S_EXEC,
    S_DONE
  } state_t;

  function automatic logic [5:0] alu_ctl(input logic zx, input logic nx,
                                         input logic zy, input logic ny,
                                         input logic f,  input logic no);
    return (zx ? ZX : 6'd0) | (nx ? NX : 6'd0) | (zy ? ZY : 6'd0) |
           (ny ? NY : 6'd0) | (f  ? F  : 6'd0) | (no ? NO : 6'd0);
  endfunction

  // Control words for the ALU passes the sequencer uses.
  localparam logic [5:0] CTL_ZERO = alu_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  localparam logic [5:0] CTL_ADD  = alu_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  localparam logic [5:0] CTL_SUB  = alu_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  localparam logic [5:0] CTL_PASS = alu_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller driving the external TTL ALU to perform multiply,
// left shift, subtract and pass-through; the ALU output is fed back each cycle.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_c,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int unsigned CW = SHW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] n;
  logic [CW-1:0]    count;

  // SUB/PASS reuse m/n as the latched a/b operands.
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    alu_c = CTL_ZERO;
    case (state)
      S_MUL_ADD: begin
        alu_x = acc;
        alu_y = m;
        alu_c = CTL_ADD;
      end
      S_MUL_DBL, S_SHL: begin
        alu_x = m;
        alu_y = m;
        alu_c = CTL_ADD;
      end
      S_EXEC: begin
        alu_x = m;
        alu_y = n;
        alu_c = (op_q == OP_SUB) ? CTL_SUB : CTL_PASS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      m      <= '0;
      n      <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            acc  <= '0;
            m    <= a;
            n    <= b;
            case (op_t'(op))
              OP_MUL: begin
                count <= '0;
                busy  <= 1'b1;
                state <= S_MUL_ADD;
              end
              OP_SHL: begin
                count <= {1'b0, b[SHW-1:0]};
                if (b[SHW-1:0] == '0) begin
                  result <= a;
                  done   <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  busy  <= 1'b1;
                  state <= S_SHL;
                end
              end
              default: begin
                busy  <= 1'b1;
                state <= S_EXEC;
              end
            endcase
          end
        end
        S_MUL_ADD: begin
          if (n[0]) acc <= alu_out;
          state <= S_MUL_DBL;
        end
        S_MUL_DBL: begin
          m     <= alu_out;
          n     <= n >> 1;
          count <= count + CW'(1);
          if (count == LAST_ITER) begin
            result <= acc;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_MUL_ADD;
          end
        end
        S_SHL: begin
          m     <= alu_out;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result <= alu_out;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_EXEC: begin
          result <= alu_out;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural TTL ALU on the feedback path and a
// plain-arithmetic reference model for results and latencies.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] result, alu_x, alu_y, alu_out;
  logic [5:0]       alu_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ttl_alu(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [5:0] c);
    logic [WIDTH-1:0] xx, yy, o;
    xx = c[5] ? '0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? '0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  assign alu_out = ttl_alu(alu_x, alu_y, alu_c);

  alu_op_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_c   (alu_c),
    .alu_out (alu_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_result(input logic [1:0] o,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic [31:0] p;
    case (o)
      2'b00: begin
        p = 32'(x) * 32'(y);
        return p[WIDTH-1:0];
      end
      2'b01:   return x << y[SHW-1:0];
      2'b10:   return x - y;
      default: return x;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] o, input logic [WIDTH-1:0] y);
    int sh;
    sh = int'(y[SHW-1:0]);
    case (o)
      2'b00:   return 2 * WIDTH + 1;
      2'b01:   return (sh == 0) ? 1 : sh + 1;
      default: return 2;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit noisy);
    logic [WIDTH-1:0] exp_r;
    int exp_l, lat, busy_cyc;
    exp_r = model_result(o, x, y);
    exp_l = model_latency(o, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      if (noisy) begin
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'(1));
    check({tag, " latency"}, lat, exp_l);
    check({tag, " busy_cycles"}, busy_cyc, exp_l - 1);
    check({tag, " result"}, 32'(result), 32'(exp_r));
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse"}, 32'(done), 32'(0));
    check({tag, " idle_after"}, 32'(busy), 32'(0));
    check({tag, " result_held"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset result", 32'(result), 32'(0));
    check("idle alu_c", 32'(alu_c), 32'(42));
    check("idle alu_x", 32'(alu_x), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mul300x200", 2'b00, 16'd300, 16'd200, 1'b0);
    run_op("mul_trunc", 2'b00, 16'h1234, 16'h0100, 1'b0);
    run_op("mul_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("shl15", 2'b01, 16'h0001, 16'd15, 1'b0);
    run_op("shl0", 2'b01, 16'hABCD, 16'd0, 1'b0);
    run_op("sub5m7", 2'b10, 16'd5, 16'd7, 1'b0);
    run_op("pass", 2'b11, 16'h5A5A, 16'h1111, 1'b0);
    run_op("mul3x4_noisy", 2'b00, 16'd3, 16'd4, 1'b1);
    run_op("shl_hi_ignored", 2'b01, 16'h00F3, 16'hFFF4, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Abort a multiply with reset partway through.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'd3; b = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort result", 32'(result), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort busy", 32'(busy), 32'(0));
    check("post_abort done", 32'(done), 32'(0));
    run_op("pass7", 2'b11, 16'd7, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
